pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline stall and flush controller for the 5-stage RV32 core. It complements forwarding: it handles the hazards that forwarding cannot resolve, and drives the stage-register enables and clears:
- load-use RAW stalls
- taken branch/jump redirects
- data-memory wait states

It sits beside the forwarding logic at the top level. Inputs come from the D/E/M pipeline registers. Outputs go to the F/D/E/M/W pipeline registers. It also keeps a memory-wait watchdog and stall/flush performance counters.

## Interface
- TIMEOUT, 255: consecutive memory-wait cycles before MemTimeout sets; legal range 2..65535.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RS1D  in  5  rs1 of instruction in Decode.
- RS2D  in  5  rs2 of instruction in Decode.
- RDE  in  5  rd of instruction in Execute.
- RegWriteE  in  1  Execute instruction writes rd.
- MemReadE  in  1  Execute instruction is a load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MemReqM  in  1  load/store in Memory stage.
- DMemReadyM  in  1  data memory completes access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  clear the corresponding pipeline register to a bubble.
- MemTimeout  out  1  sticky watchdog flag.
- StallCount  out  CNT_W  cycles with any Stall* asserted.
- FlushCount  out  CNT_W  cycles with FlushD or FlushE asserted.

## Operation

Hazard terms:
- mem_stall = MemReqM & ~DMemReadyM.
- redirect = PCSrcE.
- load_use = MemReadE & RegWriteE & (RDE != 0) & (RDE == RS1D | RDE == RS2D).

Output priority, evaluated combinationally every cycle. Any output not listed as 1 is 0.
1. mem_stall: StallF = StallD = StallE = StallM = 1; FlushW = 1.
   - Redirect and load-use are deferred, not lost: E and D are held, so both conditions re-evaluate once memory completes.
2. else redirect: FlushD = FlushE = 1.
   - A load-use hazard in the same cycle is discarded, because the Decode instruction is squashed.
3. else load_use: StallF = StallD = 1; FlushE = 1.
4. else: all 0.

FSM, two states, reset state RUN:
- RUN -> WAIT when mem_stall.
- WAIT -> RUN when ~mem_stall.
- WAIT -> WAIT otherwise.

The FSM does not alter outputs. It gates the watchdog only.

Watchdog:
- wait_cnt: 16-bit saturating counter.
  - Increments on each edge where mem_stall = 1.
  - Clears on any edge where mem_stall = 0.
- MemTimeout sets on the edge where mem_stall = 1 and wait_cnt == TIMEOUT-1, i.e. the edge ending the TIMEOUT-th consecutive wait cycle.
- MemTimeout stays 1 until reset. Stalls continue regardless.

Counters:
- StallCount increments on each edge where any Stall* = 1.
- FlushCount increments on each edge where FlushD | FlushE = 1.
- Both wrap modulo 2^CNT_W; no saturation.

## Timing
- Stall*/Flush* are purely combinational from the current inputs; zero-cycle latency, valid before the same rising edge.
- While rst = 0, all Stall*/Flush* are forced to 0, irrespective of inputs.
- Reset values:
  - state = RUN, wait_cnt = 0, MemTimeout = 0, StallCount = 0, FlushCount = 0.
  - Reset applies immediately on rst falling, without waiting for clk.
  - Deassertion takes effect on the first rising edge with rst = 1.
- Reset during WAIT: FSM returns to RUN and wait_cnt clears. A still-low DMemReadyM re-enters WAIT on the first edge after release.
- Load-use stall lasts exactly one cycle. The next cycle, E holds a bubble (RegWriteE = 0), so load_use is necessarily 0.
- Redirect lasts exactly one cycle per taken branch.
- Registered outputs (MemTimeout, counters) update one edge after the qualifying cycle.

## Test plan
- Load-use: MemReadE = 1, RegWriteE = 1, RDE = 5, RS2D = 5 -> StallF = StallD = FlushE = 1 for one cycle; StallCount = 1 after the edge.
- Load to x0, and non-load matches:
  - MemReadE = 1, RegWriteE = 1, RDE = 0, RS1D = 0 -> all outputs 0.
  - MemReadE = 0, RDE = RS1D = 7 -> all outputs 0.
- Simultaneous events:
  - PCSrcE = 1 with load_use true -> FlushD = FlushE = 1, StallF = 0; FlushCount += 1.
  - Then MemReqM = 1, DMemReadyM = 0 together with PCSrcE = 1 -> four stalls plus FlushW only.
- Watchdog, TIMEOUT = 4:
  - DMemReadyM low for 3 cycles -> MemTimeout stays 0, StallCount = 3.
  - DMemReadyM low for 4 consecutive cycles -> MemTimeout = 1 after the 4th edge, and stays 1 after DMemReadyM returns high.
- Reset mid-wait: assert rst = 0 during WAIT with wait_cnt = 3 -> all outputs 0 asynchronously, counters 0. After release, TIMEOUT counting restarts from 0.
- Counter wrap, CNT_W = 4: 16 stall cycles -> StallCount returns to 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl_if
// Brief    : Hazard-side inputs and stage-register control outputs of the
//            pipeline stall/flush controller, grouped as one bundle.
//            master : pipeline datapath (drives hazard info, receives controls)
//            slave  : stall/flush controller
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard information from the D/E/M pipeline registers
  logic [4:0]       RS1D;
  logic [4:0]       RS2D;
  logic [4:0]       RDE;
  logic             RegWriteE;
  logic             MemReadE;
  logic             PCSrcE;
  logic             MemReqM;
  logic             DMemReadyM;

  // Stage-register controls toward F/D/E/M/W
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;

  // Watchdog and performance counters
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output RS1D, RS2D, RDE, RegWriteE, MemReadE, PCSrcE, MemReqM, DMemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  MemTimeout, StallCount, FlushCount
  );

  modport slave (
    input  RS1D, RS2D, RDE, RegWriteE, MemReadE, PCSrcE, MemReqM, DMemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output MemTimeout, StallCount, FlushCount
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Brief    : Stall/flush controller for the 5-stage RV32 core. Resolves the
//            hazards forwarding cannot (load-use, taken redirect, data-memory
//            wait states), keeps a memory-wait watchdog and stall/flush
//            performance counters.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 255,  // consecutive wait cycles before MemTimeout (2..65535)
  parameter int CNT_W   = 32    // performance counter width
) (
  input  wire logic            clk,
  input  wire logic            rst,   // asynchronous, active-low
  pipeline_stall_ctrl_if.slave bus
);

  // Compare value for the watchdog: the edge that ends the TIMEOUT-th wait cycle
  localparam logic [15:0] c_TIMEOUT_M1 = 16'(TIMEOUT - 1);
  localparam logic [15:0] c_WAIT_MAX   = 16'hFFFF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  logic w_mem_stall;
  logic w_redirect;
  logic w_load_use;
  logic w_rd_match;

  assign w_mem_stall = bus.MemReqM & ~bus.DMemReadyM;
  assign w_redirect  = bus.PCSrcE;
  assign w_rd_match  = (bus.RDE == bus.RS1D) | (bus.RDE == bus.RS2D);
  // x0 is never a real dependency, so a load to x0 does not stall
  assign w_load_use  = bus.MemReadE & bus.RegWriteE & (bus.RDE != 5'd0) & w_rd_match;

  // --------------------------------------------------------------------------
  // Stage controls
  // --------------------------------------------------------------------------
  logic w_stall_f;
  logic w_stall_d;
  logic w_stall_e;
  logic w_stall_m;
  logic w_flush_d;
  logic w_flush_e;
  logic w_flush_w;

  // Prioritised hazard resolution; memory wait freezes everything so that a
  // pending redirect or load-use simply re-evaluates once memory completes.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (rst) begin
      if (w_mem_stall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else if (w_redirect) begin
        // Decode instruction is squashed, so any load-use on it is moot
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  assign bus.StallF = w_stall_f;
  assign bus.StallD = w_stall_d;
  assign bus.StallE = w_stall_e;
  assign bus.StallM = w_stall_m;
  assign bus.FlushD = w_flush_d;
  assign bus.FlushE = w_flush_e;
  assign bus.FlushW = w_flush_w;

  // --------------------------------------------------------------------------
  // Memory-wait FSM and watchdog
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic [15:0] wait_cnt_q;
  logic        timeout_q;

  // Track wait episodes; the counter only advances while waiting and the
  // timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (w_mem_stall) begin
            state_q    <= WAIT;
            wait_cnt_q <= 16'd1;
          end else begin
            wait_cnt_q <= 16'd0;
          end
        end
        WAIT: begin
          if (w_mem_stall) begin
            if (wait_cnt_q == c_TIMEOUT_M1) begin
              timeout_q <= 1'b1;
            end
            if (wait_cnt_q != c_WAIT_MAX) begin
              wait_cnt_q <= wait_cnt_q + 16'd1;
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 16'd0;
        end
      endcase
    end
  end

  assign bus.MemTimeout = timeout_q;

  // --------------------------------------------------------------------------
  // Performance counters (free-running, wrap on overflow)
  // --------------------------------------------------------------------------
  logic             w_any_stall;
  logic             w_any_flush;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] flush_count_q;
  logic [CNT_W-1:0] flush_count_d;

  assign w_any_stall = w_stall_f | w_stall_d | w_stall_e | w_stall_m;
  assign w_any_flush = w_flush_d | w_flush_e;

  // Next-count selection
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (w_any_stall) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (w_any_flush) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.StallCount = stall_count_q;
  assign bus.FlushCount = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Brief    : Self-checking bench for pipeline_stall_ctrl (TIMEOUT=4, CNT_W=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rde;
    logic       regw;
    logic       memr;
    logic       pcsrc;
    logic       memreq;
    logic       rdy;
    logic [3:0] exp_stall;  // {F,D,E,M}
    logic [2:0] exp_flush;  // {D,E,W}
  } vec_t;

  vec_t vecs [13];

  int n_checks = 0;
  int n_pass   = 0;

  logic [CNT_W-1:0] exp_sc;
  logic [CNT_W-1:0] exp_fc;
  logic             exp_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rde,
                       input logic regw, input logic memr, input logic pcsrc,
                       input logic memreq, input logic rdy);
    bus.RS1D       = rs1;
    bus.RS2D       = rs2;
    bus.RDE        = rde;
    bus.RegWriteE  = regw;
    bus.MemReadE   = memr;
    bus.PCSrcE     = pcsrc;
    bus.MemReqM    = memreq;
    bus.DMemReadyM = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic mem_wait();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [3:0] act_stall();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM};
  endfunction

  function automatic logic [2:0] act_flush();
    return {bus.FlushD, bus.FlushE, bus.FlushW};
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_stallcnt"}, 32'(bus.StallCount), 32'(exp_sc));
    chk({tag, "_flushcnt"}, 32'(bus.FlushCount), 32'(exp_fc));
    chk({tag, "_timeout"},  32'(bus.MemTimeout), 32'(exp_to));
  endtask

  initial begin
    //               name        rs1    rs2    rde    regw  memr  pcsrc mreq  rdy   stall    flush
    vecs[0]  = '{"lu_rs2",     5'd1,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 3'b010};
    vecs[1]  = '{"lu_rs1",     5'd9,  5'd2,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 3'b010};
    vecs[2]  = '{"load_x0",    5'd0,  5'd3,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000};
    vecs[3]  = '{"nonload",    5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000};
    vecs[4]  = '{"load_nowr",  5'd6,  5'd1,  5'd6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000};
    vecs[5]  = '{"load_nomat", 5'd4,  5'd6,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000};
    vecs[6]  = '{"redir_lu",   5'd5,  5'd0,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 3'b110};
    vecs[7]  = '{"redir",      5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 3'b110};
    vecs[8]  = '{"mem_redir",  5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b001};
    vecs[9]  = '{"mem_ready",  5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'b000};
    vecs[10] = '{"mem_wait",   5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001};
    vecs[11] = '{"noreq",      5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000};
    vecs[12] = '{"mem_lu",     5'd5,  5'd0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001};

    exp_sc = '0;
    exp_fc = '0;
    exp_to = 1'b0;

    // ---------------- reset: outputs forced low despite active hazards -----
    rst = 1'b1;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", 32'(act_stall()), 32'd0);
    chk("rst_flush", 32'(act_flush()), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_regs("rst");
    idle();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk_regs("post_rst");

    // ---------------- table-driven single-cycle vectors --------------------
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rde, vecs[i].regw, vecs[i].memr,
            vecs[i].pcsrc, vecs[i].memreq, vecs[i].rdy);
      #1;
      chk({vecs[i].name, "_stall"}, 32'(act_stall()), 32'(vecs[i].exp_stall));
      chk({vecs[i].name, "_flush"}, 32'(act_flush()), 32'(vecs[i].exp_flush));
      @(posedge clk); #1;
      if (vecs[i].exp_stall != 4'b0000) exp_sc = exp_sc + 1'b1;
      if (vecs[i].exp_flush[2:1] != 2'b00) exp_fc = exp_fc + 1'b1;
      chk_regs(vecs[i].name);
    end

    // ---------------- watchdog: 3 waits do not time out ---------------------
    idle();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mem_wait();
      @(posedge clk); #1;
      exp_sc = exp_sc + 1'b1;
    end
    chk_regs("wd3");
    idle();
    @(posedge clk); #1;

    // ---------------- watchdog: 4th consecutive wait sets the flag ----------
    for (int i = 0; i < 4; i++) begin
      mem_wait();
      @(posedge clk); #1;
      exp_sc = exp_sc + 1'b1;
      if (i == 2) chk_regs("wd4_before");
    end
    exp_to = 1'b1;
    chk_regs("wd4_set");
    idle();
    @(posedge clk); #1;
    chk_regs("wd4_sticky");

    // ---------------- reset in the middle of a wait episode -----------------
    for (int i = 0; i < 3; i++) begin
      mem_wait();
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    exp_sc = '0;
    exp_fc = '0;
    exp_to = 1'b0;
    chk("midrst_stall", 32'(act_stall()), 32'd0);
    chk("midrst_flush", 32'(act_flush()), 32'd0);
    chk_regs("midrst");
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_sc = exp_sc + 1'b1;
      if (i == 2) chk_regs("rewait3");
    end
    exp_to = 1'b1;
    chk_regs("rewait4");
    idle();

    // ---------------- counter wrap with 16 load-use cycles ------------------
    #1 rst = 1'b0;
    exp_sc = '0;
    exp_fc = '0;
    exp_to = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk_regs("wrap_start");
    for (int i = 0; i < 16; i++) begin
      drive(5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      if (i == 0) chk("wrap_lu_stall", 32'(act_stall()), 32'(4'b1100));
      @(posedge clk); #1;
      exp_sc = exp_sc + 1'b1;
      exp_fc = exp_fc + 1'b1;
      if (i == 14) chk_regs("wrap15");
    end
    chk_regs("wrap16");
    chk("wrap_zero", 32'(bus.StallCount), 32'd0);
    idle();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
